// File: rtl/id_stage.sv
// Registered instruction-decode stage: decodes a 5-bit opcode into the EX control bundle
// behind an ID/EX register with valid/ready handshake, load-use stall, MUL issue hold and flush.
module id_stage #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned RA_W     = 3,
    parameter int unsigned IMM_SEXT = 0,
    parameter int unsigned MUL_LAT  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] inst,
    input  logic [DATA_W-1:0] in_pc,
    input  logic              ex_ready,
    input  logic              flush,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_pc,
    output logic [RA_W-1:0]   out_rd,
    output logic [RA_W-1:0]   out_rs,
    output logic [DATA_W-1:0] out_imm,
    output logic [2:0]        out_alu_op,
    output logic [1:0]        out_cmp_op,
    output logic [1:0]        out_jump_op,
    output logic              out_imm_op,
    output logic              out_reg_we,
    output logic              out_mem_we,
    output logic              out_rw_sel,
    output logic              out_ab_sel,
    output logic              out_csr_wr,
    output logic              out_reg_clear,
    output logic              out_illegal
);

    localparam int unsigned CNT_RAW  = $clog2(MUL_LAT + 1);
    localparam int unsigned CNT_W    = (CNT_RAW < 2) ? 2 : CNT_RAW;
    localparam bit          MUL_HOLD = (MUL_LAT > 1);

    // Opcode map: 0..7 R-type ALU, 8..15 I-type ALU (bit 3), low three bits equal alu_op
    localparam logic [4:0] OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_MUL  = 5'd2,  OP_AND  = 5'd3;
    localparam logic [4:0] OP_OR   = 5'd4,  OP_XOR  = 5'd5,  OP_SLL  = 5'd6,  OP_SRL  = 5'd7;
    localparam logic [4:0] OP_ADDI = 5'd8,  OP_SUBI = 5'd9,  OP_MULI = 5'd10, OP_ANDI = 5'd11;
    localparam logic [4:0] OP_ORI  = 5'd12, OP_XORI = 5'd13, OP_SLLI = 5'd14, OP_SRLI = 5'd15;
    localparam logic [4:0] OP_LW   = 5'd16, OP_SW   = 5'd17, OP_BEQ  = 5'd18, OP_BLE  = 5'd19;
    localparam logic [4:0] OP_CSRR = 5'd20, OP_CSRW = 5'd21, OP_JAL  = 5'd22, OP_JR   = 5'd23;
    localparam logic [4:0] OP_LI   = 5'd24, OP_RC   = 5'd25;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [1:0] CMP_BEQ = 2'd1, CMP_BLE = 2'd2;
    localparam logic [1:0] JMP_JAL = 2'd1, JMP_JR  = 2'd2;

    typedef struct packed {
        logic [2:0] alu_op;
        logic [1:0] cmp_op;
        logic [1:0] jump_op;
        logic       imm_op;
        logic       reg_we;
        logic       mem_we;
        logic       rw_sel;
        logic       ab_sel;
        logic       csr_wr;
        logic       reg_clear;
        logic       illegal;
    } ctrl_t;

    typedef enum logic {ST_RUN, ST_MULW} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    mul_cnt_q, mul_cnt_d;
    logic                out_valid_q;
    ctrl_t               ctrl_q;
    logic [DATA_W-1:0]   pc_q, imm_q;
    logic [RA_W-1:0]     rd_q, rs_q;

    ctrl_t               dec;
    logic                imm_sel;
    logic                sext_bit;
    logic [DATA_W-1:0]   imm_ext;
    logic [4:0]          opcode;
    logic [RA_W-1:0]     inst_rd, inst_rs;
    logic                hazard, accept, is_mul;

    assign opcode  = inst[4:0];
    assign inst_rd = inst[5 +: RA_W];
    assign inst_rs = inst[8 +: RA_W];
    assign is_mul  = (opcode == OP_MUL) || (opcode == OP_MULI);

    // Opcode decode into the control bundle
    always_comb begin
        dec     = '0;
        imm_sel = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL,
            OP_ADDI, OP_SUBI, OP_MULI, OP_ANDI, OP_ORI, OP_XORI, OP_SLLI, OP_SRLI: begin
                dec.alu_op = opcode[2:0];
                dec.reg_we = 1'b1;
                dec.imm_op = opcode[3];
            end
            OP_LW: begin
                dec.alu_op = ALU_ADD;
                dec.imm_op = 1'b1;
                dec.reg_we = 1'b1;
                dec.rw_sel = 1'b1;
                dec.ab_sel = 1'b1;
            end
            OP_SW: begin
                dec.alu_op = ALU_ADD;
                dec.imm_op = 1'b1;
                dec.ab_sel = 1'b1;
                dec.mem_we = 1'b1;
            end
            OP_BEQ: dec.cmp_op = CMP_BEQ;
            OP_BLE: dec.cmp_op = CMP_BLE;
            OP_CSRR, OP_CSRW: begin
                dec.imm_op = 1'b1;
                dec.csr_wr = (opcode == OP_CSRW);
                imm_sel    = 1'b1;
            end
            OP_JAL: begin
                dec.jump_op = JMP_JAL;
                dec.reg_we  = 1'b1;
                dec.imm_op  = 1'b1;
                imm_sel     = 1'b1;
            end
            OP_JR: begin
                dec.jump_op = JMP_JR;
                dec.imm_op  = 1'b1;
                imm_sel     = 1'b1;
            end
            OP_LI: begin
                dec.alu_op = ALU_ADD;
                dec.imm_op = 1'b1;
                dec.reg_we = 1'b1;
                imm_sel    = 1'b1;
            end
            OP_RC:   dec.reg_clear = 1'b1;
            default: dec.illegal   = 1'b1;
        endcase
    end

    assign sext_bit = (IMM_SEXT != 0) && inst[DATA_W-1];
    assign imm_ext  = imm_sel ? {{8{sext_bit}}, inst[DATA_W-1:8]}
                              : {{11{sext_bit}}, inst[DATA_W-1:11]};

    // Conservative load-use check: either register field of the new word matches the load target
    assign hazard = out_valid_q && ctrl_q.rw_sel && ((inst_rs == rd_q) || (inst_rd == rd_q));

    // Issue control and MUL hold sequencing
    always_comb begin
        state_d   = state_q;
        mul_cnt_d = mul_cnt_q;
        in_ready  = !rst && !flush && (state_q == ST_RUN) && !hazard && (!out_valid_q || ex_ready);
        accept    = in_valid && in_ready;
        if (flush) begin
            state_d   = ST_RUN;
            mul_cnt_d = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (accept && is_mul && MUL_HOLD) begin
                        state_d   = ST_MULW;
                        mul_cnt_d = CNT_W'(MUL_LAT - 1);
                    end
                end
                ST_MULW: begin
                    mul_cnt_d = mul_cnt_q - CNT_W'(1);
                    if (mul_cnt_q == CNT_W'(1)) state_d = ST_RUN;
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            mul_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end

    // ID/EX register; dropping the entry clears only the side-effecting controls
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            pc_q        <= '0;
            imm_q       <= '0;
            rd_q        <= '0;
            rs_q        <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            ctrl_q      <= dec;
            pc_q        <= in_pc;
            imm_q       <= imm_ext;
            rd_q        <= inst_rd;
            rs_q        <= inst_rs;
        end else if (flush || ex_ready) begin
            out_valid_q      <= 1'b0;
            ctrl_q.reg_we    <= 1'b0;
            ctrl_q.mem_we    <= 1'b0;
            ctrl_q.csr_wr    <= 1'b0;
            ctrl_q.reg_clear <= 1'b0;
            ctrl_q.jump_op   <= 2'b00;
            ctrl_q.cmp_op    <= 2'b00;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_pc        = pc_q;
    assign out_rd        = rd_q;
    assign out_rs        = rs_q;
    assign out_imm       = imm_q;
    assign out_alu_op    = ctrl_q.alu_op;
    assign out_cmp_op    = ctrl_q.cmp_op;
    assign out_jump_op   = ctrl_q.jump_op;
    assign out_imm_op    = ctrl_q.imm_op;
    assign out_reg_we    = ctrl_q.reg_we;
    assign out_mem_we    = ctrl_q.mem_we;
    assign out_rw_sel    = ctrl_q.rw_sel;
    assign out_ab_sel    = ctrl_q.ab_sel;
    assign out_csr_wr    = ctrl_q.csr_wr;
    assign out_reg_clear = ctrl_q.reg_clear;
    assign out_illegal   = ctrl_q.illegal;

endmodule

// File: doc/id_stage.md
# id_stage

Parametrised, registered instruction-decode stage for the pipelined CPU core, sitting between IF/instruction memory and EX. It decodes the 5-bit opcode set defined in the shared parameter header into the same control bundle as the combinational decoder. It adds an ID/EX output register with valid/ready handshake, load-use hazard stall, a multi-cycle MUL issue hold, pipeline flush, an illegal-opcode flag and selectable immediate sign extension.

## Interface
- DATA_W, 16: instruction, immediate and PC width.
- RA_W, 3: register-address width; rd = inst[5+RA_W-1:5], rs = inst[8+RA_W-1:8].
- IMM_SEXT, 0: 0 = zero-extend immediates, 1 = sign-extend from the field MSB.
- MUL_LAT, 3: EX multiplier occupancy in cycles, ≥1.
- clk  in  1  clock.
- rst  in  1  reset; one clock, synchronous, active-high.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage accepts inst/in_pc this cycle.
- inst  in  DATA_W  instruction word; opcode = inst[4:0].
- in_pc  in  DATA_W  PC of inst.
- ex_ready  in  1  EX consumes the output register this cycle.
- flush  in  1  discard output register and any hold (branch/jump taken).
- out_valid  out  1  output register holds a live instruction.
- out_pc  out  DATA_W  registered PC.
- out_rd, out_rs  out  RA_W  register addresses.
- out_imm  out  DATA_W  extended immediate.
- out_alu_op  out  3; out_cmp_op  out  2; out_jump_op  out  2: operation selects as in the header.
- out_imm_op, out_reg_we, out_mem_we, out_rw_sel, out_ab_sel, out_csr_wr, out_reg_clear  out  1 each: control flags.
- out_illegal  out  1  opcode not in the decode set.

## Operation
- Decode (combinational, per header encodings):
  - R-type ALU: ADD/SUB/MUL/AND/OR/XOR/SLL/SRL → alu_op, reg_we.
  - I-type ALU: the I variants → additionally imm_op.
  - LW → ADD, imm_op, reg_we, rw_sel, ab_sel.
  - SW → ADD, imm_op, ab_sel, mem_we.
  - Branches: BEQ/BLE → cmp_op only.
  - CSR: CSRR → imm_op, imm_sel. CSRW → imm_op, imm_sel, csr_wr.
  - Jumps: JAL → JAL_op, reg_we, imm_op, imm_sel. JR → JR_op, imm_op, imm_sel.
  - LI → ADD, imm_op, reg_we, imm_sel.
  - RC → reg_clear.
  - Other → all zero, illegal=1.
- Immediate: imm_sel ? inst[DATA_W-1:8] : inst[DATA_W-1:11]; extended to DATA_W per IMM_SEXT.
- Accept = in_valid && in_ready. in_ready = !flush && state==RUN && !hazard && (!out_valid || ex_ready).
- Hazard (load-use): out_valid && out_rw_sel && (inst rs == out_rd || inst rd == out_rd). This is conservative for every opcode.
- Output register update, priority rst > flush > accept > ex_ready:
  - accept: load decode, out_valid=1.
  - else ex_ready: out_valid=0.
  - Whenever out_valid goes 0, reg_we, mem_we, csr_wr, reg_clear, jump_op and cmp_op are cleared. Other fields hold.
- FSM states RUN and MULW; 2-bit-or-wider counter mul_cnt:
  - RUN → MULW on accept of MUL/MULI when MUL_LAT>1, mul_cnt=MUL_LAT-1.
  - MULW: in_ready=0, mul_cnt decrements each cycle, → RUN when mul_cnt==1 is decremented. Total hold is MUL_LAT-1 cycles.
  - MULW does not touch the output register.
- flush: out_valid=0, state=RUN, mul_cnt=0, no accept that cycle.
- Reset values: every output 0 except in_ready, which is 0 during rst; state RUN, mul_cnt 0.

## Timing
- Latency: accept in cycle N → out_valid and fields visible cycle N+1.
- Throughput: 1 instr/cycle absent hazard, MUL hold or EX backpressure.
- Load-use: exactly one bubble when EX is ready; longer if ex_ready low.
- in_ready combinationally depends on inst, flush, ex_ready and registered state. Upstream must not make inst depend on in_ready.
- Simultaneous accept and ex_ready: new instruction replaces old, no bubble.
- Simultaneous flush and in_valid: instruction not accepted; upstream re-presents or drops it.
- rst mid-MULW: RUN next cycle, out_valid=0.

## Test plan
- Reset, then ADD rd=1 rs=2 with in_valid=1, ex_ready=1 → next cycle out_valid=1, alu_op=ADD_op, reg_we=1, out_rd=1, out_rs=2, out_illegal=0.
- ADDI with inst[15:11]=5'b10110, and LI with inst[15:8]=8'h85 → out_imm 0x0016 and 0x0085 (IMM_SEXT=0); 0xFFF6 and 0xFF85 (IMM_SEXT=1).
- LW rd=3, then ADD rd=4 rs=3 back-to-back, ex_ready=1 → in_ready=0 for one cycle, one out_valid=0 bubble, ADD issued the following cycle.
- MULI, MUL_LAT=3, followed by ADD held valid → in_ready low exactly 2 cycles after MULI accept, ADD accepted on the third.
- ex_ready=0 for 4 cycles with SW in the output register → SW fields stable, in_ready=0. Then flush=1 → out_valid=0, mem_we=0 next cycle.
- Opcode outside the set, e.g. 5'b11111 if unassigned → out_illegal=1, all control flags 0, out_valid=1.
